// File: rtl/mem_access_ctrl_if.sv
// Core/bank bundle for the nRisc data-memory initiator. The controller attaches through
// the master modport; the core and memory bank attach through the slave modport.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    // A transfer happens on the clock edge where valid and ready are both high. A valid
    // source holds its payload until that edge. rd_valid is the exception: it has no ready.
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              op_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_rdata,
        output req_ready, wr_ready, rd_valid, rd_data, op_done,
               mem_addr, mem_wdata, mem_rd_en, mem_wr_en
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_rdata,
        input  req_ready, wr_ready, rd_valid, rd_data, op_done,
               mem_addr, mem_wdata, mem_rd_en, mem_wr_en
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store burst initiator for the nRisc 256x8 data-memory bank.
// Define MEMCTL_STATS_EN to add saturating completed-beat counters (stat_rd_cnt/stat_wr_cnt).
module mem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    mem_access_ctrl_if.master   bus,
`ifdef MEMCTL_STATS_EN
    output logic [STAT_W-1:0]   stat_rd_cnt,
    output logic [STAT_W-1:0]   stat_wr_cnt,
`endif
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  beats_q, beats_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_wdata_q, last_wdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              op_done_q, op_done_d;
    logic              beat_fire;
    logic              last_beat;

    // State register: reset is asynchronous so mem_wr_en (decoded from state_q) drops at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            beats_q      <= '0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            op_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_q      <= beats_d;
            last_addr_q  <= last_addr_d;
            last_wdata_q <= last_wdata_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            op_done_q    <= op_done_d;
        end
    end

    // A read beat issues every READ cycle; a write beat only when the core offers data.
    assign beat_fire = (state_q == ST_READ) || ((state_q == ST_WRITE) && bus.wr_valid);
    assign last_beat = beat_fire && (beats_q == '0);

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_d      = beats_q;
        rd_valid_d   = (state_q == ST_READ);
        rd_data_d    = rd_data_q;
        op_done_d    = last_beat;
        last_addr_d  = bus.mem_addr;
        last_wdata_d = bus.mem_wdata;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    cur_addr_d = bus.req_addr;
                    beats_d    = bus.req_len;
                    state_d    = bus.req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                if (state_q == ST_READ) begin
                    rd_data_d = bus.mem_rdata;
                end
                if (beat_fire) begin
                    cur_addr_d = cur_addr_q + 1'b1;
                    if (last_beat) begin
                        beats_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beats_d = beats_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin decode; mem_addr/mem_wdata hold their last driven value while idle.
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.wr_ready  = (state_q == ST_WRITE);
        bus.mem_rd_en = (state_q == ST_READ);
        bus.mem_wr_en = (state_q == ST_WRITE) && bus.wr_valid;
        bus.mem_addr  = (state_q == ST_IDLE) ? last_addr_q : cur_addr_q;
        bus.mem_wdata = (state_q == ST_WRITE) ? bus.wr_data : last_wdata_q;
        bus.rd_valid  = rd_valid_q;
        bus.rd_data   = rd_data_q;
        bus.op_done   = op_done_q;
        dbg_state     = state_q;
    end

`ifdef MEMCTL_STATS_EN
    logic [STAT_W-1:0] stat_rd_q, stat_rd_d;
    logic [STAT_W-1:0] stat_wr_q, stat_wr_d;

    // A read beat is complete when it is handed to the core; a write beat when the bank commits it.
    always_comb begin
        stat_rd_d = stat_rd_q;
        stat_wr_d = stat_wr_q;
        if (rd_valid_q && !(&stat_rd_q)) stat_rd_d = stat_rd_q + 1'b1;
        if (bus.mem_wr_en && !(&stat_wr_q)) stat_wr_d = stat_wr_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            stat_rd_q <= stat_rd_d;
            stat_wr_q <= stat_wr_d;
        end
    end

    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 256x8 bank model (negedge read latch, posedge write).
module tb_mem_access_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int STAT_W = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();
  logic [1:0] dbg_state;
`ifdef MEMCTL_STATS_EN
  logic [STAT_W-1:0] stat_rd_cnt;
  logic [STAT_W-1:0] stat_wr_cnt;
`endif

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .STAT_W(STAT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.master),
`ifdef MEMCTL_STATS_EN
    .stat_rd_cnt(stat_rd_cnt),
    .stat_wr_cnt(stat_wr_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- bank model ----------------
  logic [7:0] bank [256];
  logic       both_en_seen = 1'b0;

  initial for (int i = 0; i < 256; i++) bank[i] = 8'h00;
  always @(posedge clock) if (bus.mem_wr_en) bank[bus.mem_addr] <= bus.mem_wdata;
  always @(negedge clock) if (bus.mem_rd_en) bus.mem_rdata <= bank[bus.mem_addr];
  always @(negedge clock) if (bus.mem_rd_en && bus.mem_wr_en) both_en_seen = 1'b1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic send_req(input logic wr, input logic [7:0] a, input logic [3:0] l);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_len   = l;
    for (int i = 0; i < 40 && !bus.req_ready; i++) tick();
    check("req_ready_at_accept", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic store_burst(input logic [7:0] a, input logic [3:0] l, input logic [127:0] data,
                             input int gap_beat, input int gap_len);
    logic [7:0] ea;
    send_req(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (i == gap_beat) begin
        for (int g = 0; g < gap_len; g++) begin
          bus.wr_valid  = 1'b0;
          bus.req_valid = 1'b1;
          #1;
          check("gap_no_write", {31'd0, bus.mem_wr_en}, 32'd0);
          check("busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
          tick();
        end
        bus.req_valid = 1'b0;
      end
      ea = a + 8'(i);
      bus.wr_valid = 1'b1;
      bus.wr_data  = data[8*i +: 8];
      #1;
      check("wr_beat_en", {31'd0, bus.mem_wr_en}, 32'd1);
      check("wr_beat_addr", {24'd0, bus.mem_addr}, {24'd0, ea});
      check("wr_no_early_done", {31'd0, bus.op_done}, 32'd0);
      tick();
    end
    bus.wr_valid = 1'b0;
    check("wr_op_done", {31'd0, bus.op_done}, 32'd1);
    check("wr_back_idle", {30'd0, dbg_state}, 32'd0);
    tick();
    check("wr_op_done_pulse", {31'd0, bus.op_done}, 32'd0);
  endtask

  task automatic load_burst(input logic [7:0] a, input logic [3:0] l, input logic [127:0] exp);
    logic [7:0] last_a;
    send_req(1'b0, a, l);
    check("rd_not_yet_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rd_en_first", {31'd0, bus.mem_rd_en}, 32'd1);
    check("rd_addr_first", {24'd0, bus.mem_addr}, {24'd0, a});
    for (int i = 0; i <= int'(l); i++) begin
      tick();
      check("rd_valid", {31'd0, bus.rd_valid}, 32'd1);
      check("rd_data", {24'd0, bus.rd_data}, {24'd0, exp[8*i +: 8]});
      check("rd_op_done", {31'd0, bus.op_done}, {31'd0, i == int'(l)});
    end
    check("rd_trailing_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    last_a = a + 8'(l);
    check("rd_valid_ends", {31'd0, bus.rd_valid}, 32'd0);
    check("rd_en_off", {31'd0, bus.mem_rd_en}, 32'd0);
    check("rd_addr_holds", {24'd0, bus.mem_addr}, {24'd0, last_a});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, "_wr_ready"}, {31'd0, bus.wr_ready}, 32'd0);
    check({tag, "_rd_valid"}, {31'd0, bus.rd_valid}, 32'd0);
    check({tag, "_rd_data"}, {24'd0, bus.rd_data}, 32'd0);
    check({tag, "_op_done"}, {31'd0, bus.op_done}, 32'd0);
    check({tag, "_mem_rd_en"}, {31'd0, bus.mem_rd_en}, 32'd0);
    check({tag, "_mem_wr_en"}, {31'd0, bus.mem_wr_en}, 32'd0);
    check({tag, "_mem_addr"}, {24'd0, bus.mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{wr: 1'b1, addr: 8'h20, data: 8'h3C, exp: 8'h3C};
    vecs[1] = '{wr: 1'b1, addr: 8'h21, data: 8'hC3, exp: 8'hC3};
    vecs[2] = '{wr: 1'b0, addr: 8'h20, data: 8'h00, exp: 8'h3C};
    vecs[3] = '{wr: 1'b0, addr: 8'h21, data: 8'h00, exp: 8'hC3};
    vecs[4] = '{wr: 1'b1, addr: 8'h20, data: 8'hFF, exp: 8'hFF};
    vecs[5] = '{wr: 1'b0, addr: 8'h20, data: 8'h00, exp: 8'hFF};
    vecs[6] = '{wr: 1'b0, addr: 8'h10, data: 8'h00, exp: 8'hA5};
    vecs[7] = '{wr: 1'b0, addr: 8'h80, data: 8'h00, exp: 8'h00};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;

    tick();
    tick();
    check_reset_values("in_reset");
    @(negedge clock);
    reset = 1'b0;
    tick();
    check_reset_values("idle");

    store_burst(8'h10, 4'd0, 128'hA5, -1, 0);
    check("bank_10", {24'd0, bank[8'h10]}, 32'hA5);
    load_burst(8'h10, 4'd0, 128'hA5);

    store_burst(8'hFE, 4'd3, 128'h04030201, 2, 2);
    check("bank_FE", {24'd0, bank[8'hFE]}, 32'h01);
    check("bank_FF", {24'd0, bank[8'hFF]}, 32'h02);
    check("bank_00", {24'd0, bank[8'h00]}, 32'h03);
    check("bank_01", {24'd0, bank[8'h01]}, 32'h04);
    load_burst(8'hFE, 4'd3, 128'h04030201);

`ifdef MEMCTL_STATS_EN
    check("stat_wr_5", {28'd0, stat_wr_cnt}, 32'd5);
    check("stat_rd_5", {28'd0, stat_rd_cnt}, 32'd5);
`endif

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].wr) begin
        store_burst(vecs[v].addr, 4'd0, {120'd0, vecs[v].data}, -1, 0);
        check("vec_bank", {24'd0, bank[vecs[v].addr]}, {24'd0, vecs[v].exp});
      end else begin
        load_burst(vecs[v].addr, 4'd0, {120'd0, vecs[v].exp});
      end
    end

    check("rd_wr_never_together", {31'd0, both_en_seen}, 32'd0);

    // Reset lands while beat 2 of a 4-beat store is being offered.
    send_req(1'b1, 8'h40, 4'd3);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h09;
    tick();
    bus.wr_data  = 8'h08;
    tick();
    bus.wr_data  = 8'h07;
    #1;
    check("abort_pre_wr_en", {31'd0, bus.mem_wr_en}, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_values("abort");
    bus.wr_valid = 1'b0;
    tick();
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("abort_bank_40", {24'd0, bank[8'h40]}, 32'h09);
    check("abort_bank_41", {24'd0, bank[8'h41]}, 32'h08);
    check("abort_bank_42", {24'd0, bank[8'h42]}, 32'h00);
    check("abort_bank_43", {24'd0, bank[8'h43]}, 32'h00);

`ifdef MEMCTL_STATS_EN
    check("stat_wr_reset", {28'd0, stat_wr_cnt}, 32'd0);
    check("stat_rd_reset", {28'd0, stat_rd_cnt}, 32'd0);
    store_burst(8'hA0, 4'd15, 128'h0, -1, 0);
    load_burst(8'hA0, 4'd15, 128'h0);
    load_burst(8'hA0, 4'd3, 128'h0);
    check("stat_wr_sat", {28'd0, stat_wr_cnt}, 32'd15);
    check("stat_rd_sat", {28'd0, stat_rd_cnt}, 32'd15);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
